// File: rtl/core_dma_multi.sv
// Multi-channel page-to-port DMA engine. Halts the CPU via O_cpu_ready and
// copies bytes from {page, offset} to {P_DEST_PAGE, dest}, one step per phy2 fall.
module core_dma_multi #(
    parameter int          P_CHANNELS    = 2,
    parameter logic [15:0] P_REG_BASE    = 16'h4020,
    parameter logic [15:0] P_LEGACY_ADDR = 16'h4014,
    parameter logic [7:0]  P_DEST_PAGE   = 8'h20,
    parameter bit          P_ALIGN       = 1'b1
) (
    input  logic                  I_clock,
    input  logic                  I_reset,
    input  logic                  I_phy2,
    input  logic [15:0]           I_cpu_addr,
    input  logic [7:0]            I_cpu_wr_data,
    input  logic                  I_cpu_rdwr,
    output logic [7:0]            O_cpu_rd_data,
    output logic                  O_cpu_ready,
    output logic [15:0]           O_addr,
    output logic [7:0]            O_wr_data,
    output logic                  O_rdwr,
    input  logic [7:0]            I_rd_data,
    output logic                  O_busy,
    output logic [P_CHANNELS-1:0] O_done
);

    // state | meaning
    // IDLE  | CPU owns the bus; launch lowest pending channel on a step
    // WAIT  | one alignment halt step before the first read
    // PULL  | read source byte {page, offset}
    // PUSH  | write captured byte to {P_DEST_PAGE, dest}; count down
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PULL, S_PUSH} state_t;

    localparam int CW = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1;

    state_t                  state;
    logic                    last_phy2;
    logic                    strobe;
    logic                    cpu_wr;
    logic                    legacy_wr;
    logic [7:0]              src_page [P_CHANNELS];
    logic [7:0]              src_off  [P_CHANNELS];
    logic [7:0]              len_m1   [P_CHANNELS];
    logic [7:0]              dest_lo  [P_CHANNELS];
    logic [P_CHANNELS-1:0]   pending;
    logic [P_CHANNELS-1:0]   done_flag;
    logic [P_CHANNELS-1:0]   ch_busy;
    logic [P_CHANNELS-1:0]   reg_hit;
    logic [CW-1:0]           cur_ch;
    logic [CW-1:0]           next_ch;
    logic [7:0]              off_cnt;
    logic [7:0]              byte_cnt;
    logic [7:0]              data_q;

    function automatic logic [15:0] base_of(input int c);
        return P_REG_BASE + 16'(c * 4);
    endfunction

    assign strobe    = last_phy2 & ~I_phy2;
    assign cpu_wr    = strobe & ~I_cpu_rdwr;
    assign legacy_wr = cpu_wr && (I_cpu_addr == P_LEGACY_ADDR) && !ch_busy[0];

    always_comb begin
        reg_hit = '0;
        ch_busy = '0;
        next_ch = '0;
        for (int c = 0; c < P_CHANNELS; c++) begin
            reg_hit[c] = ((I_cpu_addr & 16'hFFFC) == base_of(c));
            ch_busy[c] = pending[c] | ((state != S_IDLE) && (cur_ch == CW'(c)));
        end
        // descending scan so the lowest pending index wins
        for (int c = P_CHANNELS - 1; c >= 0; c--) begin
            if (pending[c]) next_ch = CW'(c);
        end
    end

    always_comb begin
        O_cpu_rd_data = I_rd_data;
        for (int c = 0; c < P_CHANNELS; c++) begin
            if (reg_hit[c]) begin
                case (I_cpu_addr[1:0])
                    2'd0:    O_cpu_rd_data = src_page[c];
                    2'd1:    O_cpu_rd_data = src_off[c];
                    2'd2:    O_cpu_rd_data = len_m1[c];
                    default: O_cpu_rd_data = {6'b0, done_flag[c], ch_busy[c]};
                endcase
            end
        end
    end

    always_comb begin
        O_addr    = I_cpu_addr;
        O_wr_data = I_cpu_wr_data;
        O_rdwr    = I_cpu_rdwr;
        case (state)
            S_WAIT: O_rdwr = 1'b1;
            S_PULL: begin
                O_addr = {src_page[cur_ch], off_cnt};
                O_rdwr = 1'b1;
            end
            S_PUSH: begin
                O_addr    = {P_DEST_PAGE, dest_lo[cur_ch]};
                O_rdwr    = 1'b0;
                O_wr_data = data_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state       <= S_IDLE;
            last_phy2   <= 1'b0;
            pending     <= '0;
            done_flag   <= '0;
            O_done      <= '0;
            O_cpu_ready <= 1'b1;
            O_busy      <= 1'b0;
            cur_ch      <= '0;
            off_cnt     <= '0;
            byte_cnt    <= '0;
            data_q      <= '0;
            for (int c = 0; c < P_CHANNELS; c++) begin
                src_page[c] <= '0;
                src_off[c]  <= '0;
                len_m1[c]   <= '0;
                dest_lo[c]  <= '0;
            end
        end else begin
            last_phy2 <= I_phy2;
            O_done    <= '0;
            if (strobe) begin
                for (int c = 0; c < P_CHANNELS; c++) begin
                    if (cpu_wr && reg_hit[c] && !ch_busy[c]) begin
                        case (I_cpu_addr[1:0])
                            2'd0: src_page[c] <= I_cpu_wr_data;
                            2'd1: src_off[c]  <= I_cpu_wr_data;
                            2'd2: len_m1[c]   <= I_cpu_wr_data;
                            default: begin
                                dest_lo[c]   <= I_cpu_wr_data;
                                pending[c]   <= 1'b1;
                                done_flag[c] <= 1'b0;
                            end
                        endcase
                    end
                end
                if (legacy_wr) begin
                    src_page[0] <= I_cpu_wr_data;
                    src_off[0]  <= 8'h00;
                    len_m1[0]   <= 8'hFF;
                    dest_lo[0]  <= 8'h04;
                    pending[0]  <= 1'b1;
                end
                case (state)
                    S_IDLE: begin
                        if (|pending) begin
                            cur_ch           <= next_ch;
                            pending[next_ch] <= 1'b0;
                            off_cnt          <= src_off[next_ch];
                            byte_cnt         <= len_m1[next_ch];
                            O_cpu_ready      <= 1'b0;
                            O_busy           <= 1'b1;
                            state            <= P_ALIGN ? S_WAIT : S_PULL;
                        end
                    end
                    S_WAIT: state <= S_PULL;
                    S_PULL: begin
                        data_q <= I_rd_data;
                        state  <= S_PUSH;
                    end
                    S_PUSH: begin
                        off_cnt <= off_cnt + 8'd1;
                        if (byte_cnt == 8'd0) begin
                            O_done[cur_ch]    <= 1'b1;
                            done_flag[cur_ch] <= 1'b1;
                            O_cpu_ready       <= 1'b1;
                            O_busy            <= 1'b0;
                            state             <= S_IDLE;
                        end else begin
                            byte_cnt <= byte_cnt - 8'd1;
                            state    <= S_PULL;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
